lsu_mmio: RTL

Parametrised load-store unit for the single-cycle/pipelined RV32I core. It combines a byte-addressable data memory with memory-mapped output registers (LEDR, LEDG, N hex digits, LCD) and input ports (switches, buttons). It supports RV32I sub-word loads and stores (LB/LBU/LH/LHU/LW, SB/SH/SW) with sign and zero extension, registered load response, misalignment and unmapped-address detection. Sits between the ALU address/rs2 path and writeback.

---
 rtl/lsu_mmio.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mmio.sv
// lsu_mmio: RV32I load-store unit with byte-addressable DMEM and memory-mapped LED/HEX/LCD/switch/button registers.
// Latency: stores commit at the sampling edge; loads and error pulses respond one cycle after the request edge.
// Backpressure: none, one access per cycle is always accepted. Define LSU_INPUT_SYNC_EN to 2-flop synchronise io_sw_i/io_btn_i.
module lsu_mmio #(
   parameter int DMEM_DEPTH = 2048,
   parameter int NUM_HEX    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [2:0]           funct3_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          st_data_i,
   output logic [31:0]          ld_data_o,
   output logic                 ld_valid_o,
   output logic                 err_o,
   input  logic [31:0]          io_sw_i,
   input  logic [31:0]          io_btn_i,
   output logic [31:0]          io_ledr_o,
   output logic [31:0]          io_ledg_o,
   output logic [7*NUM_HEX-1:0] io_hex_o,
   output logic [31:0]          io_lcd_o
);

   localparam int          AW         = $clog2(DMEM_DEPTH);
   localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
   localparam logic [31:0] DMEM_LIMIT = DMEM_BASE + 32'(4 * DMEM_DEPTH);
   localparam logic [31:0] HEX_LIMIT  = 32'h0000_7020 + 32'(4 * NUM_HEX);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state;
   logic        resp_ld_q;
   logic [31:0] mem [DMEM_DEPTH];
   logic [31:0] ledr_q, ledg_q, lcd_q;
   logic [6:0]  hex_q [NUM_HEX];
   logic [31:0] sw_v, btn_v;

   logic [31:0]   word_a;
   logic [AW-1:0] dmem_idx;
   logic          dmem_hit, ledr_hit, ledg_hit, hex_hit, lcd_hit, sw_hit, btn_hit;
   logic          illegal, misaligned, bad, do_store;
   logic [3:0]    be;
   logic [31:0]   wdata, rd_word, lane_sh, ld_ext;

   assign word_a   = {addr_i[31:2], 2'b00};
   assign dmem_idx = addr_i[AW+1:2];

   // Address decode; DMEM limit is below 0x1_0000 so the range test also rejects nonzero upper bits
   always_comb begin
      dmem_hit = (addr_i >= DMEM_BASE) && (addr_i < DMEM_LIMIT);
      ledr_hit = (word_a == 32'h0000_7000);
      ledg_hit = (word_a == 32'h0000_7010);
      hex_hit  = (word_a >= 32'h0000_7020) && (word_a < HEX_LIMIT);
      lcd_hit  = (word_a == 32'h0000_7040);
      sw_hit   = (word_a == 32'h0000_7800);
      btn_hit  = (word_a == 32'h0000_7810);
   end

   // Request legality: funct3 encoding, alignment and mapping
   always_comb begin
      illegal = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = we_i;
         default:                illegal = 1'b1;
      endcase
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      bad      = illegal || misaligned ||
                 !(dmem_hit || ledr_hit || ledg_hit || hex_hit || lcd_hit || sw_hit || btn_hit);
      do_store = req_i && we_i && !bad;
   end

   // Byte-lane enables and replicated store data so each lane sees its byte
   always_comb begin
      case (funct3_i[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_i[1:0];
            wdata = {4{st_data_i[7:0]}};
         end
         2'b01: begin
            be    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data_i[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data_i;
         end
      endcase
   end

   function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] en);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (en[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

`ifdef LSU_INPUT_SYNC_EN
   logic [31:0] sw_s1, sw_s2, btn_s1, btn_s2;
   // Two-flop synchronisers for the asynchronous switch/button inputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         sw_s1  <= io_sw_i;
         sw_s2  <= sw_s1;
         btn_s1 <= io_btn_i;
         btn_s2 <= btn_s1;
      end
   end
   assign sw_v  = sw_s2;
   assign btn_v = btn_s2;
`else
   assign sw_v  = io_sw_i;
   assign btn_v = io_btn_i;
`endif

   // Read-word mux, then shift the addressed lane down and extend it
   always_comb begin
      rd_word = '0;
      if (dmem_hit)      rd_word = mem[dmem_idx];
      else if (ledr_hit) rd_word = ledr_q;
      else if (ledg_hit) rd_word = ledg_q;
      else if (lcd_hit)  rd_word = lcd_q;
      else if (sw_hit)   rd_word = sw_v;
      else if (btn_hit)  rd_word = btn_v;
      else if (hex_hit) begin
         for (int i = 0; i < NUM_HEX; i++)
            if (word_a[4:2] == 3'(i)) rd_word = {25'b0, hex_q[i]};
      end
      lane_sh = rd_word >> {addr_i[1:0], 3'b000};
      case (funct3_i)
         3'b000:  ld_ext = {{24{lane_sh[7]}}, lane_sh[7:0]};
         3'b100:  ld_ext = {24'b0, lane_sh[7:0]};
         3'b001:  ld_ext = {{16{lane_sh[15]}}, lane_sh[15:0]};
         3'b101:  ld_ext = {16'b0, lane_sh[15:0]};
         default: ld_ext = lane_sh;
      endcase
   end

   // DMEM byte-lane write; contents are not reset and nothing commits on a reset edge
   always_ff @(posedge clk_i) begin
      if (!rst_i && do_store && dmem_hit)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
   end

   // Peripheral output registers; HEX digits only take byte lane 0 bits [6:0]
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ledr_q <= '0;
         ledg_q <= '0;
         lcd_q  <= '0;
         for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= '0;
      end else if (do_store) begin
         if (ledr_hit) ledr_q <= merge_lanes(ledr_q, wdata, be);
         if (ledg_hit) ledg_q <= merge_lanes(ledg_q, wdata, be);
         if (lcd_hit)  lcd_q  <= merge_lanes(lcd_q, wdata, be);
         for (int i = 0; i < NUM_HEX; i++)
            if (hex_hit && (word_a[4:2] == 3'(i)) && be[0]) hex_q[i] <= wdata[6:0];
      end
   end

   // Response pipeline: RESP for one cycle after any load or rejected request
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         resp_ld_q <= 1'b0;
         err_o     <= 1'b0;
         ld_data_o <= '0;
      end else begin
         state     <= (req_i && (!we_i || bad)) ? RESP : IDLE;
         resp_ld_q <= req_i && !we_i;
         err_o     <= req_i && bad;
         if (req_i && !we_i) ld_data_o <= bad ? 32'h0 : ld_ext;
      end
   end

   assign ld_valid_o = (state == RESP) && resp_ld_q;
   assign io_ledr_o  = ledr_q;
   assign io_ledg_o  = ledg_q;
   assign io_lcd_o   = lcd_q;

   for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
      assign io_hex_o[7*gi +: 7] = hex_q[gi];
   end

endmodule
